layer_serializer: RTL and testbench

Converts the parallel output of a neuron layer (NN per-neuron valid strobes and an NN×dataWidth result bus) into the serial x_valid/x_in stream that the next layer consumes, one value per cycle, neuron 0 first. Sits between consecutive layers of the MNIST network. Holds one frame in transmission plus one pending frame so that back-to-back layer results are not lost.

---
 rtl/layer_serializer.sv | 138 +++++++++++++
 tb/tb_layer_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Purpose: serialises one NN-word neuron-layer result per frame into a one-word-per-cycle stream, neuron 0 first.
// Latency: element k of a frame appears k+1 cycles after the cycle in which the frame completes; back-to-back frames stream with no gap.
// Backpressure: none downstream; one frame is buffered while another is sent, and any further completed frame is dropped with sticky overflow.
module layer_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [dataWidth-1:0] word_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NN-1:0]   mask;
    logic            pend_full, pend_full_d, overflow_d;
    logic            frame_cmp, consumed;
    word_t           col_buf [NN];
    word_t           cmp_word [NN];
    word_t           shift [NN];
    word_t           shift_d [NN];
    word_t           pend [NN];
    word_t           pend_d [NN];

    // Slices arriving in the completing cycle join the frame; earlier captures win over repeats.
    always_comb begin
        frame_cmp = &(mask | in_valid);
        for (int i = 0; i < NN; i++) begin
            cmp_word[i] = mask[i] ? col_buf[i] : in_data[i*dataWidth +: dataWidth];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask <= '0;
        end else if (frame_cmp) begin
            mask <= '0;
        end else begin
            mask <= mask | in_valid;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (in_valid[i] && !mask[i]) begin
                col_buf[i] <= in_data[i*dataWidth +: dataWidth];
            end
        end
        shift <= shift_d;
        pend  <= pend_d;
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        shift_d     = shift;
        pend_d      = pend;
        pend_full_d = pend_full;
        overflow_d  = overflow;
        consumed    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_cmp) begin
                    shift_d  = cmp_word;
                    cnt_d    = '0;
                    state_d  = SEND;
                    consumed = 1'b1;
                end
            end
            SEND: begin
                if (cnt == LAST) begin
                    cnt_d = '0;
                    if (pend_full) begin
                        shift_d     = pend;
                        pend_full_d = 1'b0;
                    end else if (frame_cmp) begin
                        shift_d  = cmp_word;
                        consumed = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                    for (int i = 0; i < NN - 1; i++) begin
                        shift_d[i] = shift[i+1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A pending slot freed at frame end is immediately available to this cycle's frame.
        if (frame_cmp && !consumed) begin
            if (!pend_full_d) begin
                pend_d      = cmp_word;
                pend_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_full  <= 1'b0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pend_full  <= pend_full_d;
            overflow   <= overflow_d;
            out_valid  <= (state_d == SEND);
            frame_done <= (state_d == SEND) && (cnt_d == LAST);
            if (state_d == SEND) begin
                out_data <= shift_d[0];
            end
        end
    end

    assign busy = (state == SEND) || pend_full;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: each task drives a scenario and compares the captured output stream.
module tb_layer_serializer;
    localparam int NN = 10;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NN-1:0]    in_valid = '0;
    logic [NN*DW-1:0] in_data = '0;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             frame_done;
    logic             busy;
    logic             overflow;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [DW-1:0] q_dat[$];
    int            q_cyc[$];
    logic          q_fd[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_dat.push_back(out_data);
            q_cyc.push_back(cyc);
            q_fd.push_back(frame_done);
        end
    end

    int n_pass = 0;
    int n_total = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [NN*DW-1:0] mk(input logic [DW-1:0] base);
        logic [NN*DW-1:0] d;
        for (int i = 0; i < NN; i++) d[i*DW +: DW] = base + DW'(i);
        return d;
    endfunction

    task automatic drive(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, output int t);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        t = cyc;
        in_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        q_dat.delete();
        q_cyc.delete();
        q_fd.delete();
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_out_data got %h exp 0000", out_data); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int t;
        int n;
        clr();
        drive('1, mk(16'h0100), t);
        idle(13);
        n = q_dat.size();
        n_total++; if (n !== 10) $display("FAIL single_len got %0d exp 10", n); else n_pass++;
        for (int k = 0; k < n && k < 10; k++) begin
            n_total++; if (q_dat[k] !== 16'h0100 + DW'(k)) $display("FAIL single_data[%0d] got %h exp %h", k, q_dat[k], 16'h0100 + DW'(k)); else n_pass++;
            n_total++; if (q_cyc[k] !== t + k) $display("FAIL single_cycle[%0d] got %0d exp %0d", k, q_cyc[k], t + k); else n_pass++;
            n_total++; if (q_fd[k] !== (k == 9)) $display("FAIL single_frame_done[%0d] got %b exp %b", k, q_fd[k], (k == 9)); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_stagger();
        int t0;
        int t;
        int n;
        logic [NN*DW-1:0] dup;
        logic [DW-1:0] exp_v;
        clr();
        dup = '0;
        dup[2*DW +: DW] = 16'hDEAD;
        drive(10'h01F, mk(16'h0200), t0);
        drive(10'h004, dup, t);
        idle(1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL stagger_early_valid got %b exp 0", out_valid); else n_pass++;
        drive(10'h3E0, mk(16'h0200), t);
        idle(12);
        n = q_dat.size();
        n_total++; if (n !== 10) $display("FAIL stagger_len got %0d exp 10", n); else n_pass++;
        if (n > 0) begin
            n_total++; if (q_cyc[0] !== t0 + 3) $display("FAIL stagger_start got %0d exp %0d", q_cyc[0], t0 + 3); else n_pass++;
        end
        for (int k = 0; k < n && k < 10; k++) begin
            exp_v = 16'h0200 + DW'(k);
            n_total++; if (q_dat[k] !== exp_v) $display("FAIL stagger_data[%0d] got %h exp %h", k, q_dat[k], exp_v); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int tb;
        int n;
        logic [DW-1:0] exp_v;
        clr();
        drive('1, mk(16'h0300), t);
        idle(2);
        drive('1, mk(16'h0400), tb);
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_pending got %b exp 1", busy); else n_pass++;
        idle(22);
        n = q_dat.size();
        n_total++; if (n !== 20) $display("FAIL b2b_len got %0d exp 20", n); else n_pass++;
        for (int k = 0; k < n && k < 20; k++) begin
            exp_v = (k < 10) ? 16'h0300 + DW'(k) : 16'h0400 + DW'(k - 10);
            n_total++; if (q_dat[k] !== exp_v) $display("FAIL b2b_data[%0d] got %h exp %h", k, q_dat[k], exp_v); else n_pass++;
            n_total++; if (q_cyc[k] !== t + k) $display("FAIL b2b_cycle[%0d] got %0d exp %0d", k, q_cyc[k], t + k); else n_pass++;
            n_total++; if (q_fd[k] !== (k % 10 == 9)) $display("FAIL b2b_frame_done[%0d] got %b exp %b", k, q_fd[k], (k % 10 == 9)); else n_pass++;
        end
        n_total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b exp 0", overflow); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_after got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_last_cycle();
        int t;
        int tb;
        int n;
        logic [DW-1:0] exp_v;
        clr();
        drive('1, mk(16'h0600), t);
        idle(9);
        n_total++; if (frame_done !== 1'b1) $display("FAIL last_fd_now got %b exp 1", frame_done); else n_pass++;
        n_total++; if (out_data !== 16'h0609) $display("FAIL last_data_now got %h exp 0609", out_data); else n_pass++;
        drive('1, mk(16'h0700), tb);
        idle(12);
        n = q_dat.size();
        n_total++; if (n !== 20) $display("FAIL last_len got %0d exp 20", n); else n_pass++;
        for (int k = 0; k < n && k < 20; k++) begin
            exp_v = (k < 10) ? 16'h0600 + DW'(k) : 16'h0700 + DW'(k - 10);
            n_total++; if (q_dat[k] !== exp_v) $display("FAIL last_data[%0d] got %h exp %h", k, q_dat[k], exp_v); else n_pass++;
            n_total++; if (q_cyc[k] !== t + k) $display("FAIL last_cycle[%0d] got %0d exp %0d", k, q_cyc[k], t + k); else n_pass++;
        end
        n_total++; if (overflow !== 1'b0) $display("FAIL last_overflow got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_overflow();
        int t;
        int tx;
        int n;
        logic [DW-1:0] exp_v;
        clr();
        drive('1, mk(16'h0800), t);
        drive('1, mk(16'h0900), tx);
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_before got %b exp 0", overflow); else n_pass++;
        drive('1, mk(16'h0A00), tx);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else n_pass++;
        idle(25);
        n = q_dat.size();
        n_total++; if (n !== 20) $display("FAIL ovf_len got %0d exp 20", n); else n_pass++;
        for (int k = 0; k < n && k < 20; k++) begin
            exp_v = (k < 10) ? 16'h0800 + DW'(k) : 16'h0900 + DW'(k - 10);
            n_total++; if (q_dat[k] !== exp_v) $display("FAIL ovf_data[%0d] got %h exp %h", k, q_dat[k], exp_v); else n_pass++;
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ovf_busy_after got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t;
        int n;
        clr();
        drive('1, mk(16'h0B00), t);
        idle(3);
        #2;
        rstn = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL midrst_out_data got %h exp 0000", out_data); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL midrst_frame_done got %b exp 0", frame_done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow got %b exp 0", overflow); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        clr();
        idle(15);
        n = q_dat.size();
        n_total++; if (n !== 0) $display("FAIL midrst_no_output got %0d exp 0", n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stagger();
        test_back_to_back();
        test_last_cycle();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
